snapshot_player: RTL
====================

# snapshot_player

Parallel-to-serial pattern transmitter: the transmit-side counterpart of the snapshot shift register. It accepts PWidth-bit words over a valid/ready handshake and shifts them out SWidth bits per enabled cycle, least-significant slice first. A snapshot register with matching parameters and the same enable reconstructs each word exactly. It sits in the BERT pattern path, driving serial test data into the link or a loopback, with an optional loop mode that replays a word indefinitely.

## Interface
- PWidth, 32, word width; must be an integer multiple of SWidth
- SWidth, 1, slice width emitted per enabled beat
- clk  input  1  sole clock; all logic on posedge
- reset  input  1  synchronous, active-high
- en  input  1  beat enable; one slice is emitted per cycle with en=1
- abort  input  1  synchronous flush of all words; outputs return to reset values
- loop  input  1  replay the current word when it is exhausted and no new word is pending
- load_data  input  PWidth  word to transmit
- load_valid  input  1  load_data valid
- load_ready  output  1  hold buffer empty; a word is accepted on load_valid && load_ready
- data_out  output  SWidth  registered serial slice
- data_out_valid  output  1  data_out carries a real slice
- busy  output  1  state is RUN or the hold buffer is full
- done  output  1  one-cycle pulse when the last slice of the last word is emitted and the block returns to IDLE

## Operation
- Constant NBeats = PWidth/SWidth. Beat counter width = clog2(NBeats+1).
- Storage:
  - hold buffer (hold_q, hold_valid)
  - shift register shreg
  - replay copy word_q
  - beat counter cnt
  - state {IDLE, RUN}
- load_ready = !hold_valid, registered. A hold transfer and a new accept never occur in the same cycle; the earliest next accept is the cycle after hold drains.
- IDLE:
  - If hold_valid, then shreg, word_q <= hold_q; cnt <= NBeats; hold_valid <= 0; go to RUN.
  - This transfer does not depend on en.
  - An en beat in IDLE drives data_out_valid <= 0 and data_out <= 0.
- RUN, on an en beat:
  - data_out <= shreg[SWidth-1:0]; data_out_valid <= 1.
  - shreg <= shreg >> SWidth; cnt <= cnt-1.
- RUN, last beat (en && cnt==1), resolved in priority order:
  - hold_valid: reload shreg and word_q from hold_q, cnt <= NBeats, stay in RUN (seamless, no gap beat).
  - else loop: shreg <= word_q, cnt <= NBeats, stay in RUN.
  - else: go to IDLE and pulse done.
- en=0: data_out, data_out_valid, shreg and cnt hold their values. The handshake and the IDLE transfer still operate.
- abort, and also reset:
  - state <= IDLE; hold_valid <= 0; cnt <= 0; shreg, word_q, data_out <= 0.
  - data_out_valid, done <= 0; load_ready <= 1 on the following cycle.
  - abort has priority over every other event, including a concurrent load accept, which is dropped.
- Reset values: data_out=0, data_out_valid=0, load_ready=1, busy=0, done=0.
- Changing loop mid-word takes effect only at the next last-beat decision.

## Timing
- Accept at edge E0 leads to the hold→shreg transfer at E1 (IDLE). The first en edge at or after E2 presents slice 0 on data_out.
- Back-to-back words with en held high: NBeats consecutive data_out_valid=1 cycles per word, with no bubbles, provided each next word is accepted before the current word's last beat.
- done asserts in the cycle after the edge that emitted the final slice, for exactly one cycle.
- busy is combinational: (state==RUN) || hold_valid.

## Structure
- Shared BERT package: nbeats(PWidth, SWidth) function, state enum {IDLE, RUN}, and a parameter check (PWidth % SWidth == 0 and PWidth ≥ SWidth; elaboration error otherwise).
- Single module; no sub-module is warranted. The hold buffer is inline logic, not a FIFO instance.

## Test plan
- Reset mid-RUN (PWidth=32, SWidth=1, word 0xA5A5_0F0F): assert reset at beat 7 -> next cycle all outputs are at reset values, load_ready=1, and no further data_out_valid.
- Single word, SWidth=1, word 0x0000_0001, en=1 -> data_out sequence 1 then 31 zeros, then done pulse; loopback snapshot reads 0x0000_0001.
- Back-to-back, SWidth=4, words 0x76543210 then 0xFEDCBA98, second accepted during the first -> 16 contiguous valid nibbles 0,1,…,F with no gap; a single done.
- Loop mode, SWidth=8, word 0xDEADBEEF, loop=1 for 3 words' worth of beats -> EF,BE,AD,DE repeated 3 times, no done; drop loop -> one more pass completes, then done.
- en gating, SWidth=2, en toggling 1,0,1,0 -> data_out changes only after en=1 edges; 16 valid beats total; word reconstructs intact.
- abort concurrent with load_valid in RUN -> word is not accepted, outputs are cleared, and load_ready=1 on the following cycle.

Source files
------------

// File: rtl/snapshot_player_pkg.sv
// Shared BERT pattern-path definitions: beat-count helper, FSM state codes and
// the parameter legality check used by the serial transmit/receive pair.
package snapshot_player_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    function automatic int nbeats(input int pwidth, input int swidth);
        return pwidth / swidth;
    endfunction

    function automatic bit params_ok(input int pwidth, input int swidth);
        return (swidth > 0) && (pwidth >= swidth) && ((pwidth % swidth) == 0);
    endfunction

endpackage

// File: rtl/snapshot_player.sv
// Parallel-to-serial pattern transmitter: one SWidth slice per en beat, LSB slice first;
// accept->first slice takes two edges; single-entry hold buffer drives load_ready.
import snapshot_player_pkg::*;

module snapshot_player #(
    parameter int PWidth = 32,
    parameter int SWidth = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              abort,
    input  logic              loop,
    input  logic [PWidth-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic [SWidth-1:0] data_out,
    output logic              data_out_valid,
    output logic              busy,
    output logic              done
);

    localparam int NBeats = nbeats(PWidth, SWidth);
    localparam int CntW   = $clog2(NBeats + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(NBeats);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    if (!params_ok(PWidth, SWidth)) begin : g_param_err
        $error("snapshot_player: PWidth must be a non-zero multiple of SWidth");
    end

    logic              state_q,    state_d;
    logic [PWidth-1:0] hold_q,     hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic [PWidth-1:0] shreg_q,    shreg_d;
    logic [PWidth-1:0] word_q,     word_d;
    logic [CntW-1:0]   cnt_q,      cnt_d;
    logic [SWidth-1:0] dout_q,     dout_d;
    logic              dvld_q,     dvld_d;
    logic              done_q,     done_d;

    // Accept and hold->shreg transfer are mutually exclusive: both key off hold_vld_q.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        shreg_d    = shreg_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        dvld_d     = dvld_q;
        done_d     = 1'b0;

        if (load_valid && !hold_vld_q) begin
            hold_d     = load_data;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    dout_d = '0;
                    dvld_d = 1'b0;
                end
                if (hold_vld_q) begin
                    shreg_d    = hold_q;
                    word_d     = hold_q;
                    cnt_d      = CntFull;
                    hold_vld_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (en) begin
                    dout_d  = shreg_q[SWidth-1:0];
                    dvld_d  = 1'b1;
                    shreg_d = shreg_q >> SWidth;
                    cnt_d   = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        // Pending word wins over replay so a loop can be broken seamlessly.
                        if (hold_vld_q) begin
                            shreg_d    = hold_q;
                            word_d     = hold_q;
                            cnt_d      = CntFull;
                            hold_vld_d = 1'b0;
                        end else if (loop) begin
                            shreg_d = word_q;
                            cnt_d   = CntFull;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            shreg_q    <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            dvld_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shreg_q    <= shreg_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dvld_q     <= dvld_d;
            done_q     <= done_d;
        end
    end

    assign load_ready     = !hold_vld_q;
    assign data_out       = dout_q;
    assign data_out_valid = dvld_q;
    assign busy           = (state_q == ST_RUN) || hold_vld_q;
    assign done           = done_q;

endmodule
